// File: rtl/lbp_engine_p.sv
// Local-binary-pattern engine: raster-walks interior pixels of a 2**ROW_LOG2 x 2**COL_LOG2
// grey image over a stallable read port and writes one 8-bit code per pixel, plus optional border zero-fill.
module lbp_engine_p #(
    parameter int COL_LOG2 = 3,
    parameter int ROW_LOG2 = 3,
    parameter int DATA_W   = 8,
    parameter int AW       = COL_LOG2 + ROW_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] thr,
    input  logic              border_zero,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [AW-1:0]     gray_addr,
    input  logic [DATA_W-1:0] gray_data,
    output logic              lbp_write,
    output logic [AW-1:0]     lbp_addr,
    output logic [7:0]        lbp_data,
    output logic              busy,
    output logic              finish
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_C   = 3'd1,
        RD_N   = 3'd2,
        WRITE  = 3'd3,
        BORDER = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [COL_LOG2-1:0] X_ONE  = COL_LOG2'(1);
    localparam logic [ROW_LOG2-1:0] Y_ONE  = ROW_LOG2'(1);
    localparam logic [COL_LOG2-1:0] X_LAST = COL_LOG2'((2 ** COL_LOG2) - 2);
    localparam logic [ROW_LOG2-1:0] Y_LAST = ROW_LOG2'((2 ** ROW_LOG2) - 2);
    localparam logic [COL_LOG2-1:0] X_MAX  = {COL_LOG2{1'b1}};
    localparam logic [ROW_LOG2-1:0] Y_MAX  = {ROW_LOG2{1'b1}};

    state_t                state_r;
    logic [COL_LOG2-1:0]   x_r;
    logic [ROW_LOG2-1:0]   y_r;
    logic [2:0]            nidx_r;
    logic [2:0]            pn_r;
    logic                  p_r;
    logic                  pcenter_r;
    logic [DATA_W-1:0]     centre_r;
    logic [DATA_W-1:0]     thr_r;
    logic                  bz_r;
    logic [7:0]            code_r;

    logic [7:0]            code_next_s;
    logic                  cmp_bit_s;
    logic [COL_LOG2-1:0]   nx_s;
    logic [ROW_LOG2-1:0]   ny_s;
    logic                  last_s;
    logic [AW-1:0]         border_next_s;

    // Address of neighbour k (0..7) around centre (y,x), row-major order
    function automatic logic [AW-1:0] nbr_addr(input logic [ROW_LOG2-1:0] y,
                                               input logic [COL_LOG2-1:0] x,
                                               input logic [2:0] k);
        logic [ROW_LOG2-1:0] r;
        logic [COL_LOG2-1:0] c;
        case (k)
            3'd0:    begin r = y - Y_ONE; c = x - X_ONE; end
            3'd1:    begin r = y - Y_ONE; c = x;         end
            3'd2:    begin r = y - Y_ONE; c = x + X_ONE; end
            3'd3:    begin r = y;         c = x - X_ONE; end
            3'd4:    begin r = y;         c = x + X_ONE; end
            3'd5:    begin r = y + Y_ONE; c = x - X_ONE; end
            3'd6:    begin r = y + Y_ONE; c = x;         end
            default: begin r = y + Y_ONE; c = x + X_ONE; end
        endcase
        return {r, c};
    endfunction

    // Threshold compare at DATA_W+1 bits so an overflowing centre+thr never matches
    always_comb begin
        cmp_bit_s   = ({1'b0, gray_data} >= ({1'b0, centre_r} + {1'b0, thr_r}));
        code_next_s = code_r;
        if (p_r && !pcenter_r) begin
            code_next_s[pn_r] = cmp_bit_s;
        end else begin
            code_next_s = code_r;
        end
    end

    // Next interior raster position and last-pixel detect
    always_comb begin
        last_s = (x_r == X_LAST) && (y_r == Y_LAST);
        if (x_r == X_LAST) begin
            nx_s = X_ONE;
            ny_s = y_r + Y_ONE;
        end else begin
            nx_s = x_r + X_ONE;
            ny_s = y_r;
        end
    end

    // Next border address: interior rows jump from col 0 straight to the last column
    always_comb begin
        if ((lbp_addr[AW-1:COL_LOG2] != {ROW_LOG2{1'b0}}) &&
            (lbp_addr[AW-1:COL_LOG2] != Y_MAX) &&
            (lbp_addr[COL_LOG2-1:0] == {COL_LOG2{1'b0}})) begin
            border_next_s = {lbp_addr[AW-1:COL_LOG2], X_MAX};
        end else begin
            border_next_s = lbp_addr + AW'(1);
        end
    end

    // Main control FSM with registered outputs and read-data capture tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            x_r       <= '0;
            y_r       <= '0;
            nidx_r    <= 3'd0;
            pn_r      <= 3'd0;
            p_r       <= 1'b0;
            pcenter_r <= 1'b0;
            centre_r  <= '0;
            thr_r     <= '0;
            bz_r      <= 1'b0;
            code_r    <= 8'd0;
            gray_req  <= 1'b0;
            gray_addr <= '0;
            lbp_write <= 1'b0;
            lbp_addr  <= '0;
            lbp_data  <= 8'd0;
            busy      <= 1'b0;
            finish    <= 1'b0;
        end else begin
            p_r       <= gray_req & gray_ready;
            pcenter_r <= (state_r == RD_C);
            pn_r      <= nidx_r;
            code_r    <= code_next_s;
            lbp_write <= 1'b0;
            if (p_r && pcenter_r) begin
                centre_r <= gray_data;
            end
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r   <= RD_C;
                        x_r       <= X_ONE;
                        y_r       <= Y_ONE;
                        thr_r     <= thr;
                        bz_r      <= border_zero;
                        code_r    <= 8'd0;
                        busy      <= 1'b1;
                        finish    <= 1'b0;
                        gray_req  <= 1'b1;
                        gray_addr <= {Y_ONE, X_ONE};
                    end
                end
                RD_C: begin
                    if (gray_ready) begin
                        state_r   <= RD_N;
                        nidx_r    <= 3'd0;
                        gray_addr <= nbr_addr(y_r, x_r, 3'd0);
                    end
                end
                RD_N: begin
                    if (gray_req) begin
                        if (gray_ready) begin
                            if (nidx_r == 3'd7) begin
                                gray_req <= 1'b0;
                            end else begin
                                nidx_r    <= nidx_r + 3'd1;
                                gray_addr <= nbr_addr(y_r, x_r, nidx_r + 3'd1);
                            end
                        end
                    end else if (p_r) begin
                        // last neighbour lands this cycle; code_next_s is complete
                        state_r   <= WRITE;
                        lbp_write <= 1'b1;
                        lbp_addr  <= {y_r, x_r};
                        lbp_data  <= code_next_s;
                    end
                end
                WRITE: begin
                    code_r <= 8'd0;
                    x_r    <= nx_s;
                    y_r    <= ny_s;
                    if (last_s) begin
                        if (bz_r) begin
                            state_r   <= BORDER;
                            lbp_write <= 1'b1;
                            lbp_addr  <= '0;
                            lbp_data  <= 8'd0;
                        end else begin
                            state_r <= DONE;
                            busy    <= 1'b0;
                            finish  <= 1'b1;
                        end
                    end else begin
                        state_r   <= RD_C;
                        gray_req  <= 1'b1;
                        gray_addr <= {ny_s, nx_s};
                    end
                end
                BORDER: begin
                    if (lbp_addr == {AW{1'b1}}) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        finish  <= 1'b1;
                    end else begin
                        lbp_write <= 1'b1;
                        lbp_addr  <= border_next_s;
                        lbp_data  <= 8'd0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    gray_req <= 1'b0;
                    busy     <= 1'b0;
                    finish   <= 1'b0;
                end
            endcase
        end
    end
endmodule
